game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Game-level sequencer for the Mario display pipeline. It sequences the title screen, play, death animation, respawn, game-over and win phases. It owns the lives count and drives the shared `game_on` and `dead_reset` controls consumed by the sprite, background, life-icon and start-screen blocks. All phase timing is counted in video frames derived from the VGA vertical-sync signal.

## Interface
Parameters:
- `LIVES`, 3: lives loaded at game start; legal range 1–3.
- `DEATH_FRAMES`, 60: frames spent in the death animation; legal range 1–255.
- `WIN_STEP`, 400: `bg_step` value at or above which the level is won.
- `START_KEY`, 8'h28: USB HID keycode (Enter) that starts or restarts the game.
- `INVULN_FRAMES`, 90: post-respawn invulnerability length in frames; only used with `GAME_FLOW_INVULN_EN`.

Ports:
- `Clk`  in  1  system clock, 50 MHz.
- `Reset_n`  in  1  asynchronous reset, active-low.
- `frame_clk`  in  1  VGA vertical-sync signal; asynchronous to `Clk`.
- `keycode`  in  32  four packed HID keycode bytes from the USB host.
- `mario_hit`  in  1  level collision with fire or Kuba; may be a single-cycle pulse.
- `mario_fell`  in  1  level; Mario is below the floor line.
- `bg_step`  in  9  background scroll position.
- `game_on`  out  1  high in every state except TITLE.
- `dead_reset`  out  1  position and object reset to all movers.
- `lives_left`  out  2  remaining lives.
- `blink`  out  1  Mario visibility mask; 0 means hide Mario.
- `game_over`  out  1  high in GAMEOVER.
- `win`  out  1  high in WIN.
- `state`  out  3  FSM state code, for debug and LEDs.

## Operation
- **Frame tick:** `frame_clk` passes through a 2-flop synchronizer plus a rising-edge detect. This produces `tick`, a one-`Clk` pulse per frame.
- **Start-key edge:** `start_hit` is high when any `keycode` byte equals `START_KEY`. `start_edge` fires on a 0→1 transition of `start_hit`, registered. A key held across states never retriggers.
- **Hit latch:** `mario_hit | mario_fell` is OR-ed into a sticky latch. The latch is cleared on every `tick` and on every state change, so pulses shorter than a frame are never lost.
- **States:** TITLE=0, RESPAWN=1, PLAY=2, DYING=3, GAMEOVER=4, WIN=5.
- **TITLE:** on `start_edge`, load `lives_left`=`LIVES` and go to RESPAWN.
- **RESPAWN:** `dead_reset`=1 for the whole state. On the next `tick`, go to PLAY.
- **PLAY:** evaluated on `tick` only, in this priority order:
  - If `bg_step` ≥ `WIN_STEP`, go to WIN.
  - Otherwise, if the hit latch is set, decrement `lives_left`, clear the frame counter and go to DYING.
- **DYING:**
  - The frame counter increments on each `tick`.
  - `blink` = NOT counter[2], so Mario toggles every 4 frames.
  - When the counter reaches `DEATH_FRAMES`: go to GAMEOVER if `lives_left`=0, else go to RESPAWN.
- **GAMEOVER / WIN:** on `start_edge`, go to TITLE.
- **Win and hit on the same tick:** WIN is taken and the life is not decremented.
- **Decrement at zero:** `lives_left` never decrements below 0.
- **`blink`:** 1 in all states other than DYING, except as modified by `GAME_FLOW_INVULN_EN`.
- **`dead_reset`:** registered and glitch-free. It is high only in RESPAWN.

## Timing
- **Reset values:** state=TITLE, `game_on`=0, `dead_reset`=0, `lives_left`=`LIVES`, `blink`=1, `game_over`=0, `win`=0. Counters and the hit latch are 0.
- **`Reset_n` asserted mid-game:** immediate return to TITLE with the outputs above. There is no frame-boundary wait.
- **`tick` latency:** 3 `Clk` cycles after a `frame_clk` rising edge.
- **Output timing:** all outputs are registered and change 1 `Clk` after the state transition cycle.
- **RESPAWN length:** `dead_reset` is high from entry into RESPAWN until the first `tick` after entry. This guarantees at least one frame-clock edge for downstream blocks sampling on `frame_clk`.
- **`start_edge`:** one `Clk` after `keycode` first matches `START_KEY`.
- **DYING length:** exactly `DEATH_FRAMES` ticks. On the transition out of DYING, the counter wraps to 0.

## Configuration
- **Macro:** `GAME_FLOW_INVULN_EN`.
- **Defined:**
  - On exit from RESPAWN into PLAY, an invulnerability counter loads `INVULN_FRAMES`.
  - While the counter is nonzero, the hit latch is forced to 0 and `blink` toggles every 4 frames.
  - The counter decrements on each `tick`.
  - `bg_step` win detection is unaffected.
- **Undefined:** the counter is not built. Hits are honoured on the first PLAY tick, and `blink`=1 throughout PLAY.

## Test plan
- **Reset and start:** `Reset_n` low, then high; `keycode`=0x00000028 → `start_edge`, state RESPAWN, `dead_reset`=1, `lives_left`=3. After the next `frame_clk` edge: PLAY, `game_on`=1, `dead_reset`=0.
- **Short hit:** in PLAY, a 1-cycle `mario_hit` between frames → at the next `tick`: DYING, `lives_left`=2. After 60 ticks: RESPAWN, `dead_reset` high for one frame.
- **Game over and restart:** three deaths → GAMEOVER, `game_over`=1, `lives_left`=0. Holding Enter from before does not restart; release and press → TITLE, `game_on`=0.
- **Win beats hit:** `bg_step`=400 and `mario_hit` asserted on the same tick → WIN, `win`=1, `lives_left` unchanged.
- **Async reset mid-DYING:** `Reset_n` pulsed low during DYING frame 30 → TITLE immediately, `lives_left`=3, `blink`=1.
- **Invulnerability:** with `GAME_FLOW_INVULN_EN`, a hit 10 frames after respawn is ignored. A hit at frame 91 → DYING. Without the macro, a hit at frame 1 → DYING.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Purpose: game-level phase sequencer (title, respawn, play, dying, game-over, win); owns lives.
// Latency: frame tick 3 Clk after frame_clk rise; outputs registered, 1 Clk after the deciding cycle.
// Backpressure: none; phases advance only on frame ticks or start-key edges, inputs never stalled.
//
// Ports:
//   Clk, Reset_n       system clock, async active-low reset
//   frame_clk          VGA vsync, asynchronous to Clk (synchronised here)
//   keycode[31:0]      four HID keycode bytes; any byte == START_KEY is a start press
//   mario_hit/fell     death causes; latched until the next frame tick
//   bg_step[8:0]       scroll position; >= WIN_STEP wins the level
//   game_on, dead_reset, lives_left, blink, game_over, win, state   registered status/controls
//
// Optional feature macro: GAME_FLOW_INVULN_EN (post-respawn invulnerability window).
module game_flow_ctrl #(
  parameter int         LIVES         = 3,
  parameter int         DEATH_FRAMES  = 60,
  parameter int         WIN_STEP      = 400,
  parameter logic [7:0] START_KEY     = 8'h28,
  parameter int         INVULN_FRAMES = 90
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [31:0] keycode,
  input  logic        mario_hit,
  input  logic        mario_fell,
  input  logic [8:0]  bg_step,
  output logic        game_on,
  output logic        dead_reset,
  output logic [1:0]  lives_left,
  output logic        blink,
  output logic        game_over,
  output logic        win,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_TITLE    = 3'd0,
    S_RESPAWN  = 3'd1,
    S_PLAY     = 3'd2,
    S_DYING    = 3'd3,
    S_GAMEOVER = 3'd4,
    S_WIN      = 3'd5
  } state_t;

  localparam logic [1:0] LIVES_C    = 2'(LIVES);
  localparam logic [7:0] DYING_LAST = 8'(DEATH_FRAMES - 1);
  // One extra bit so a WIN_STEP above the 9-bit range simply never wins.
  localparam logic [9:0] WIN_C      = 10'(WIN_STEP);

  state_t     st, nxt_st;
  logic [1:0] nxt_lives;
  logic [7:0] cnt, nxt_cnt;
  logic       hit_lat, nxt_hit;
  logic       nxt_blink;

  logic fsync1, fsync2, fsync3, tick;
  logic start_hit, start_q, start_edge;
  logic hit_in;

`ifdef GAME_FLOW_INVULN_EN
  localparam logic [15:0] INV_C = 16'(INVULN_FRAMES);
  logic [15:0] inv, nxt_inv;
`endif

  // Frame tick: two-flop synchroniser, third flop for edge history, registered pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsync1 <= 1'b0;
      fsync2 <= 1'b0;
      fsync3 <= 1'b0;
      tick   <= 1'b0;
    end else begin
      fsync1 <= frame_clk;
      fsync2 <= fsync1;
      fsync3 <= fsync2;
      tick   <= fsync2 & ~fsync3;
    end
  end

  always_comb begin
    start_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (keycode[8*i +: 8] == START_KEY) start_hit = 1'b1;
    end
  end

  // Edge, not level: a key held across GAMEOVER/WIN -> TITLE cannot chain restarts.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      start_q    <= 1'b0;
      start_edge <= 1'b0;
    end else begin
      start_q    <= start_hit;
      start_edge <= start_hit & ~start_q;
    end
  end

  assign hit_in = mario_hit | mario_fell;

  always_comb begin
    nxt_st    = st;
    nxt_lives = lives_left;
    nxt_cnt   = cnt;
`ifdef GAME_FLOW_INVULN_EN
    nxt_inv   = inv;
`endif
    case (st)
      S_TITLE: begin
        if (start_edge) begin
          nxt_lives = LIVES_C;
          nxt_st    = S_RESPAWN;
        end
      end
      S_RESPAWN: begin
        if (tick) begin
          nxt_st = S_PLAY;
`ifdef GAME_FLOW_INVULN_EN
          nxt_inv = INV_C;
`endif
        end
      end
      S_PLAY: begin
        if (tick) begin
`ifdef GAME_FLOW_INVULN_EN
          if (inv != 16'd0) nxt_inv = inv - 16'd1;
`endif
          // Win has priority: a simultaneous hit costs no life.
          if ({1'b0, bg_step} >= WIN_C) begin
            nxt_st = S_WIN;
          end else if (hit_lat) begin
            nxt_lives = (lives_left != 2'd0) ? lives_left - 2'd1 : 2'd0;
            nxt_cnt   = 8'd0;
            nxt_st    = S_DYING;
          end
        end
      end
      S_DYING: begin
        if (tick) begin
          if (cnt == DYING_LAST) begin
            nxt_cnt = 8'd0;
            nxt_st  = (lives_left == 2'd0) ? S_GAMEOVER : S_RESPAWN;
          end else begin
            nxt_cnt = cnt + 8'd1;
          end
        end
      end
      S_GAMEOVER, S_WIN: begin
        if (start_edge) nxt_st = S_TITLE;
      end
      default: nxt_st = S_TITLE;
    endcase

    // Sticky hit: restart from the current-cycle hit on tick or phase change so
    // a pulse landing on that very cycle still counts for the next frame.
    nxt_hit = (tick || (nxt_st != st)) ? hit_in : (hit_lat | hit_in);
`ifdef GAME_FLOW_INVULN_EN
    if (nxt_inv != 16'd0) nxt_hit = 1'b0;
`endif

    nxt_blink = 1'b1;
    if (nxt_st == S_DYING) begin
      nxt_blink = ~nxt_cnt[2];
`ifdef GAME_FLOW_INVULN_EN
    end else if ((nxt_st == S_PLAY) && (nxt_inv != 16'd0)) begin
      nxt_blink = ~nxt_inv[2];
`endif
    end
  end

  // Outputs are decoded from next-state values so they are true registers
  // that switch together with the state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st         <= S_TITLE;
      lives_left <= LIVES_C;
      cnt        <= 8'd0;
      hit_lat    <= 1'b0;
      game_on    <= 1'b0;
      dead_reset <= 1'b0;
      blink      <= 1'b1;
      game_over  <= 1'b0;
      win        <= 1'b0;
`ifdef GAME_FLOW_INVULN_EN
      inv        <= 16'd0;
`endif
    end else begin
      st         <= nxt_st;
      lives_left <= nxt_lives;
      cnt        <= nxt_cnt;
      hit_lat    <= nxt_hit;
      game_on    <= (nxt_st != S_TITLE);
      dead_reset <= (nxt_st == S_RESPAWN);
      blink      <= nxt_blink;
      game_over  <= (nxt_st == S_GAMEOVER);
      win        <= (nxt_st == S_WIN);
`ifdef GAME_FLOW_INVULN_EN
      inv        <= nxt_inv;
`endif
    end
  end

  assign state = st;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Purpose: directed self-checking bench for game_flow_ctrl (default parameters).
// Latency: frames are 8 Clk long; each frame task returns after its tick has been acted on.
// Backpressure: not applicable.
module tb_game_flow_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_clk;
  logic [31:0] keycode;
  logic        mario_hit;
  logic        mario_fell;
  logic [8:0]  bg_step;
  logic        game_on;
  logic        dead_reset;
  logic [1:0]  lives_left;
  logic        blink;
  logic        game_over;
  logic        win;
  logic [2:0]  state;

  int n_vec = 0;
  int n_err = 0;

  game_flow_ctrl dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .keycode    (keycode),
    .mario_hit  (mario_hit),
    .mario_fell (mario_fell),
    .bg_step    (bg_step),
    .game_on    (game_on),
    .dead_reset (dead_reset),
    .lives_left (lives_left),
    .blink      (blink),
    .game_over  (game_over),
    .win        (win),
    .state      (state)
  );

  always #5 Clk = ~Clk;

  // All driving and sampling happens on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      frame_clk = 1'b1;
      step(4);
      frame_clk = 1'b0;
      step(4);
    end
  endtask

  task automatic pulse_hit();
    mario_hit = 1'b1;
    step(1);
    mario_hit = 1'b0;
    step(2);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; frame_clk = 1'b0; keycode = 32'h0;
    mario_hit = 1'b0; mario_fell = 1'b0; bg_step = 9'd0;
    step(3);
    n_vec++; if (state !== 3'd0)      begin n_err++; $display("FAIL rst_state got %0d want 0", state); end
    n_vec++; if (game_on !== 1'b0)    begin n_err++; $display("FAIL rst_game_on got %b want 0", game_on); end
    n_vec++; if (dead_reset !== 1'b0) begin n_err++; $display("FAIL rst_dead_reset got %b want 0", dead_reset); end
    n_vec++; if (lives_left !== 2'd3) begin n_err++; $display("FAIL rst_lives got %0d want 3", lives_left); end
    n_vec++; if (blink !== 1'b1)      begin n_err++; $display("FAIL rst_blink got %b want 1", blink); end
    n_vec++; if (game_over !== 1'b0)  begin n_err++; $display("FAIL rst_game_over got %b want 0", game_over); end
    n_vec++; if (win !== 1'b0)        begin n_err++; $display("FAIL rst_win got %b want 0", win); end
    Reset_n = 1'b1;
    step(2);
    n_vec++; if (state !== 3'd0)      begin n_err++; $display("FAIL idle_title got %0d want 0", state); end
  endtask

  task automatic test_start();
    keycode = 32'h0000_0028;
    step(1); // start_edge registered, FSM not yet moved
    n_vec++; if (state !== 3'd0)      begin n_err++; $display("FAIL start_lat1 got %0d want 0", state); end
    step(1);
    n_vec++; if (state !== 3'd1)      begin n_err++; $display("FAIL start_state got %0d want 1", state); end
    n_vec++; if (dead_reset !== 1'b1) begin n_err++; $display("FAIL start_dead_reset got %b want 1", dead_reset); end
    n_vec++; if (game_on !== 1'b1)    begin n_err++; $display("FAIL start_game_on got %b want 1", game_on); end
    n_vec++; if (lives_left !== 2'd3) begin n_err++; $display("FAIL start_lives got %0d want 3", lives_left); end
    keycode = 32'h0;
    step(2);
    // tick appears 3 Clk after the frame edge; state follows on the 4th.
    frame_clk = 1'b1;
    step(3);
    n_vec++; if (state !== 3'd1)      begin n_err++; $display("FAIL tick_lat3 got %0d want 1", state); end
    step(1);
    n_vec++; if (state !== 3'd2)      begin n_err++; $display("FAIL tick_lat4 got %0d want 2", state); end
    n_vec++; if (dead_reset !== 1'b0) begin n_err++; $display("FAIL play_dead_reset got %b want 0", dead_reset); end
    n_vec++; if (blink !== 1'b1)      begin n_err++; $display("FAIL play_blink got %b want 1", blink); end
    step(4);
    frame_clk = 1'b0;
    step(4);
  endtask

  // Hit on the very first PLAY frame after respawn; also the death animation.
  task automatic test_short_hit();
    pulse_hit();
    frames(1);
    n_vec++; if (state !== 3'd3)      begin n_err++; $display("FAIL hit_state got %0d want 3", state); end
    n_vec++; if (lives_left !== 2'd2) begin n_err++; $display("FAIL hit_lives got %0d want 2", lives_left); end
    n_vec++; if (blink !== 1'b1)      begin n_err++; $display("FAIL dying_blink0 got %b want 1", blink); end
    frames(3);
    n_vec++; if (blink !== 1'b1)      begin n_err++; $display("FAIL dying_blink3 got %b want 1", blink); end
    frames(1);
    n_vec++; if (blink !== 1'b0)      begin n_err++; $display("FAIL dying_blink4 got %b want 0", blink); end
    frames(4);
    n_vec++; if (blink !== 1'b1)      begin n_err++; $display("FAIL dying_blink8 got %b want 1", blink); end
    frames(51);
    n_vec++; if (state !== 3'd3)      begin n_err++; $display("FAIL dying_59 got %0d want 3", state); end
    frames(1);
    n_vec++; if (state !== 3'd1)      begin n_err++; $display("FAIL dying_60 got %0d want 1", state); end
    n_vec++; if (dead_reset !== 1'b1) begin n_err++; $display("FAIL respawn_dr got %b want 1", dead_reset); end
    n_vec++; if (blink !== 1'b1)      begin n_err++; $display("FAIL respawn_blink got %b want 1", blink); end
    frames(1);
    n_vec++; if (state !== 3'd2)      begin n_err++; $display("FAIL respawn_play got %0d want 2", state); end
    n_vec++; if (dead_reset !== 1'b0) begin n_err++; $display("FAIL respawn_dr_off got %b want 0", dead_reset); end
  endtask

  task automatic test_game_over();
    mario_fell = 1'b1;
    frames(1);
    n_vec++; if (state !== 3'd3)      begin n_err++; $display("FAIL fell_state got %0d want 3", state); end
    n_vec++; if (lives_left !== 2'd1) begin n_err++; $display("FAIL fell_lives got %0d want 1", lives_left); end
    mario_fell = 1'b0;
    frames(61);
    n_vec++; if (state !== 3'd2)      begin n_err++; $display("FAIL go_play2 got %0d want 2", state); end
    pulse_hit();
    frames(1);
    n_vec++; if (lives_left !== 2'd0) begin n_err++; $display("FAIL go_lives0 got %0d want 0", lives_left); end
    frames(30);
    keycode = 32'h0028_0000; // held from before GAMEOVER
    frames(30);
    n_vec++; if (state !== 3'd4)      begin n_err++; $display("FAIL go_state got %0d want 4", state); end
    n_vec++; if (game_over !== 1'b1)  begin n_err++; $display("FAIL go_flag got %b want 1", game_over); end
    n_vec++; if (lives_left !== 2'd0) begin n_err++; $display("FAIL go_lives got %0d want 0", lives_left); end
    step(20);
    n_vec++; if (state !== 3'd4)      begin n_err++; $display("FAIL go_held_key got %0d want 4", state); end
    keycode = 32'h0;
    step(2);
    keycode = 32'h2800_0000;
    step(2);
    n_vec++; if (state !== 3'd0)      begin n_err++; $display("FAIL go_restart got %0d want 0", state); end
    n_vec++; if (game_on !== 1'b0)    begin n_err++; $display("FAIL go_game_on got %b want 0", game_on); end
    n_vec++; if (game_over !== 1'b0)  begin n_err++; $display("FAIL go_flag_off got %b want 0", game_over); end
    keycode = 32'h0;
    step(2);
  endtask

  task automatic test_win_beats_hit();
    keycode = 32'h0000_2800;
    step(2);
    n_vec++; if (lives_left !== 2'd3) begin n_err++; $display("FAIL win_reload got %0d want 3", lives_left); end
    keycode = 32'h0;
    frames(1);
    bg_step = 9'd399;
    frames(1);
    n_vec++; if (state !== 3'd2)      begin n_err++; $display("FAIL win_399 got %0d want 2", state); end
    bg_step = 9'd400;
    pulse_hit();
    frames(1);
    n_vec++; if (state !== 3'd5)      begin n_err++; $display("FAIL win_state got %0d want 5", state); end
    n_vec++; if (win !== 1'b1)        begin n_err++; $display("FAIL win_flag got %b want 1", win); end
    n_vec++; if (lives_left !== 2'd3) begin n_err++; $display("FAIL win_lives got %0d want 3", lives_left); end
    bg_step = 9'd0;
    keycode = 32'h0000_0028;
    step(2);
    n_vec++; if (state !== 3'd0)      begin n_err++; $display("FAIL win_restart got %0d want 0", state); end
    n_vec++; if (win !== 1'b0)        begin n_err++; $display("FAIL win_flag_off got %b want 0", win); end
    keycode = 32'h0;
    step(2);
  endtask

  task automatic test_async_reset();
    keycode = 32'h0000_0028;
    step(2);
    keycode = 32'h0;
    frames(1);
    pulse_hit();
    frames(1);
    frames(30);
    n_vec++; if (state !== 3'd3)      begin n_err++; $display("FAIL ar_dying got %0d want 3", state); end
    n_vec++; if (blink !== 1'b0)      begin n_err++; $display("FAIL ar_blink30 got %b want 0", blink); end
    #2 Reset_n = 1'b0;
    #1;
    n_vec++; if (state !== 3'd0)      begin n_err++; $display("FAIL ar_state got %0d want 0", state); end
    n_vec++; if (lives_left !== 2'd3) begin n_err++; $display("FAIL ar_lives got %0d want 3", lives_left); end
    n_vec++; if (blink !== 1'b1)      begin n_err++; $display("FAIL ar_blink got %b want 1", blink); end
    n_vec++; if (game_on !== 1'b0)    begin n_err++; $display("FAIL ar_game_on got %b want 0", game_on); end
    @(negedge Clk);
    Reset_n = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset();
    test_start();
    test_short_hit();
    test_game_over();
    test_win_beats_hit();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
